// File: rtl/spi_byte_master.sv
// ----------------------------------------------------------------------------
// spi_byte_master
//
// Purpose:
//   Single-clock SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Shifts N-bit
//   words out on MOSI while capturing MISO. The host sees a request/write
//   handshake: di_req_o asks for the next word and wren_i supplies it. A word
//   written before the current one finishes keeps chip select low, so holding
//   wren_i high streams words back-to-back under one frame.
//
// Parameters:
//   N         word width in bits
//   CLK_DIV   pclk_i cycles per SCK half-period (>= 1)
//   PREFETCH  SCK cycles before word end at which di_req_o re-asserts (1..N-1)
//
// Ports:
//   pclk_i      in   system clock, all logic on the rising edge
//   rst_i       in   synchronous active-high reset
//   spi_ssel_o  out  chip select, active low
//   spi_sck_o   out  SPI clock, idles low
//   spi_mosi_o  out  serial data out, MSB first
//   spi_miso_i  in   serial data in
//   di_req_o    out  high while the master can accept another word
//   di_i        in   word to transmit
//   wren_i      in   write strobe, may be held high for streaming
//   wr_ack_o    out  one-cycle pulse after a word is accepted
//   do_valid_o  out  one-cycle pulse when do_o holds a new received word
//   do_o        out  last received word
//
// Configuration macro:
//   SPI_LOOPBACK_EN  when defined the receive shifter samples spi_mosi_o
//                    internally and spi_miso_i is ignored.
// ----------------------------------------------------------------------------
module spi_byte_master #(
    parameter int N        = 8,
    parameter int CLK_DIV  = 2,
    parameter int PREFETCH = 2
) (
    input  logic         pclk_i,
    input  logic         rst_i,
    output logic         spi_ssel_o,
    output logic         spi_sck_o,
    output logic         spi_mosi_o,
    input  logic         spi_miso_i,
    output logic         di_req_o,
    input  logic [N-1:0] di_i,
    input  logic         wren_i,
    output logic         wr_ack_o,
    output logic         do_valid_o,
    output logic [N-1:0] do_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N);
    localparam logic [BIT_W-1:0] REQ_AT   = BIT_W'(N - PREFETCH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_END
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_divCnt;
    logic [BIT_W-1:0] r_bitCnt;
    logic [N-1:0]     r_txShift;
    logic [N-1:0]     r_rxShift;
    logic [N-1:0]     r_holdData;
    logic             r_holdFull;
    logic             r_ssel;
    logic             r_sck;
    logic             r_mosi;
    logic             r_diReq;
    logic             r_wrAck;
    logic             r_doValid;
    logic [N-1:0]     r_do;

    logic             w_tick;
    logic             w_accept;
    logic             w_haveWord;
    logic [N-1:0]     w_nextWord;
    logic             w_reqCond;
    logic             w_rxBit;

    // One tick per SCK half-period while a frame is active.
    assign w_tick = (r_divCnt == DIV_LAST);

    // A write only counts while a request is outstanding.
    assign w_accept = r_diReq & wren_i;

    // A word accepted on the very edge a transfer could start is used directly,
    // bypassing the holding register, so it is never lost or delayed a frame.
    assign w_haveWord = r_holdFull | w_accept;
    assign w_nextWord = r_holdFull ? r_holdData : di_i;

    // Request another word when the holding register is empty and either
    // nothing is shifting or the current word is inside its prefetch window.
    assign w_reqCond = !r_holdFull &&
                       ((r_state == ST_IDLE) || (r_state == ST_END) ||
                        ((r_state == ST_SHIFT) && (r_bitCnt >= REQ_AT)));

`ifdef SPI_LOOPBACK_EN
    assign w_rxBit = r_mosi;
`else
    assign w_rxBit = spi_miso_i;
`endif

    // Main FSM: handshake, holding register, SCK generation and both shifters.
    // A word end with a pending word jumps straight back to LOAD, whose
    // half-period setup is exactly the SCK low time, so the frame stays gapless.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_divCnt   <= '0;
            r_bitCnt   <= '0;
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_holdData <= '0;
            r_holdFull <= 1'b0;
            r_ssel     <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_diReq    <= 1'b0;
            r_wrAck    <= 1'b0;
            r_doValid  <= 1'b0;
            r_do       <= '0;
        end else begin
            r_wrAck   <= w_accept;
            r_doValid <= 1'b0;
            r_diReq   <= w_accept ? 1'b0 : w_reqCond;

            if (w_accept) begin
                r_holdData <= di_i;
                r_holdFull <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_ssel   <= 1'b1;
                    r_sck    <= 1'b0;
                    r_divCnt <= '0;
                    if (w_haveWord) begin
                        r_txShift  <= w_nextWord;
                        r_mosi     <= w_nextWord[N-1];
                        r_holdFull <= 1'b0;
                        r_ssel     <= 1'b0;
                        r_bitCnt   <= '0;
                        r_state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (w_tick) begin
                        r_divCnt  <= '0;
                        r_sck     <= 1'b1;
                        r_rxShift <= {r_rxShift[N-2:0], w_rxBit};
                        r_bitCnt  <= r_bitCnt + 1'b1;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (w_tick) begin
                        r_divCnt <= '0;
                        if (r_sck) begin
                            r_sck <= 1'b0;
                            if (r_bitCnt == BIT_LAST) begin
                                r_do      <= r_rxShift;
                                r_doValid <= 1'b1;
                                if (w_haveWord) begin
                                    r_txShift  <= w_nextWord;
                                    r_mosi     <= w_nextWord[N-1];
                                    r_holdFull <= 1'b0;
                                    r_bitCnt   <= '0;
                                    r_state    <= ST_LOAD;
                                end else begin
                                    r_state <= ST_END;
                                end
                            end else begin
                                r_txShift <= {r_txShift[N-2:0], 1'b0};
                                r_mosi    <= r_txShift[N-2];
                            end
                        end else begin
                            r_sck     <= 1'b1;
                            r_rxShift <= {r_rxShift[N-2:0], w_rxBit};
                            r_bitCnt  <= r_bitCnt + 1'b1;
                        end
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end

                ST_END: begin
                    r_sck <= 1'b0;
                    if (w_tick) begin
                        r_divCnt <= '0;
                        r_ssel   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_ssel_o = r_ssel;
    assign spi_sck_o  = r_sck;
    assign spi_mosi_o = r_mosi;
    assign di_req_o   = r_diReq;
    assign wr_ack_o   = r_wrAck;
    assign do_valid_o = r_doValid;
    assign do_o       = r_do;

endmodule

// File: tb/tb_spi_byte_master.sv
// ----------------------------------------------------------------------------
// tb_spi_byte_master
//
// Directed bench for spi_byte_master (N=8, CLK_DIV=2, PREFETCH=2). Words are
// pushed to transmit/receive scoreboards when written; a monitor rebuilds each
// MOSI word from the SCK rising edges and pops the transmit queue, and pops
// the receive queue on every do_valid pulse. MISO is either tied to a constant
// or driven as the inverse of MOSI, so the expected received word is known.
// ----------------------------------------------------------------------------
module tb_spi_byte_master;

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic       spiSsel;
    logic       spiSck;
    logic       spiMosi;
    logic       spiMiso;
    logic       diReq;
    logic [7:0] diIn = 8'h00;
    logic       wren = 1'b0;
    logic       wrAck;
    logic       doValid;
    logic [7:0] doWord;

    logic       misoConst  = 1'b0;
    logic       misoInvert = 1'b0;

    int checkCount    = 0;
    int passCount     = 0;
    int failCount     = 0;
    int sckRiseCount  = 0;
    int sselRiseCount = 0;
    int sselFallCount = 0;
    int wrAckCount    = 0;
    int doValidCount  = 0;
    int extraEvents   = 0;

    logic [7:0] txQueue[$];
    logic [7:0] rxQueue[$];

    logic       prevSck   = 1'b0;
    logic       prevSsel  = 1'b1;
    logic [7:0] mosiShift = 8'h00;
    int         mosiBits  = 0;

    spi_byte_master #(
        .N        (8),
        .CLK_DIV  (2),
        .PREFETCH (2)
    ) dut (
        .pclk_i     (pclk),
        .rst_i      (rst),
        .spi_ssel_o (spiSsel),
        .spi_sck_o  (spiSck),
        .spi_mosi_o (spiMosi),
        .spi_miso_i (spiMiso),
        .di_req_o   (diReq),
        .di_i       (diIn),
        .wren_i     (wren),
        .wr_ack_o   (wrAck),
        .do_valid_o (doValid),
        .do_o       (doWord)
    );

    always #5 pclk = ~pclk;

    // Simple slave: either a constant level or the inverse of MOSI.
    assign spiMiso = misoInvert ? ~spiMosi : misoConst;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expectedRx(input logic [7:0] word);
`ifdef SPI_LOOPBACK_EN
        return word;
`else
        return misoInvert ? ~word : {8{misoConst}};
`endif
    endfunction

    // Wait (bounded) for a request, write one word and log it in the scoreboards.
    task automatic applyStimulus(input logic [7:0] word, input bit holdWren);
        int n;
        n = 0;
        while (diReq !== 1'b1 && n < 500) begin
            @(negedge pclk);
            n++;
        end
        checkOutput("di_req_wait", 32'(diReq), 32'd1);
        if (diReq === 1'b1) begin
            diIn = word;
            wren = 1'b1;
            txQueue.push_back(word);
            rxQueue.push_back(expectedRx(word));
            @(posedge pclk);
            @(negedge pclk);
            checkOutput("wr_ack", 32'(wrAck), 32'd1);
        end
        if (!holdWren) wren = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int n;
        n = 0;
        while ((doValidCount < target || spiSsel !== 1'b1) && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        checkOutput("done_in_time", 32'(n < 3000), 32'd1);
    endtask

    // Monitor: sampled on the falling pclk edge, away from the DUT's active edge.
    always @(negedge pclk) begin
        if (wrAck === 1'b1) wrAckCount++;
        if (doValid === 1'b1) begin
            doValidCount++;
            if (rxQueue.size() > 0) checkOutput("do_o", 32'(doWord), 32'(rxQueue.pop_front()));
            else extraEvents++;
        end
        if (spiSsel === 1'b1 && prevSsel === 1'b0) sselRiseCount++;
        if (spiSsel === 1'b0 && prevSsel === 1'b1) sselFallCount++;
        if (spiSck === 1'b1 && prevSck === 1'b0) begin
            sckRiseCount++;
            if (spiSsel !== 1'b0) extraEvents++;
            mosiShift = {mosiShift[6:0], spiMosi};
            mosiBits++;
            if (mosiBits == 8) begin
                mosiBits = 0;
                if (txQueue.size() > 0) checkOutput("mosi_word", 32'(mosiShift), 32'(txQueue.pop_front()));
                else extraEvents++;
            end
        end
        if (spiSsel === 1'b1) mosiBits = 0;
        prevSck  = spiSck;
        prevSsel = spiSsel;
    end

    initial begin
        int baseRise, baseValid, baseAck, baseSselRise, baseSselFall, n;
        logic [7:0] streamWords [4];
        streamWords[0] = 8'h89;
        streamWords[1] = 8'h85;
        streamWords[2] = 8'h01;
        streamWords[3] = 8'h00;

        // Reset state.
        repeat (3) @(negedge pclk);
        checkOutput("rst_ssel", 32'(spiSsel), 32'd1);
        checkOutput("rst_sck", 32'(spiSck), 32'd0);
        checkOutput("rst_mosi", 32'(spiMosi), 32'd0);
        checkOutput("rst_di_req", 32'(diReq), 32'd0);
        checkOutput("rst_wr_ack", 32'(wrAck), 32'd0);
        checkOutput("rst_do_valid", 32'(doValid), 32'd0);
        checkOutput("rst_do", 32'(doWord), 32'd0);
        rst = 1'b0;
        @(negedge pclk);
        checkOutput("di_req_after_release", 32'(diReq), 32'd1);

        // Single word 0xA5 with MISO tied high.
        $display("[TB] single word 0xA5");
        misoConst = 1'b1;
        baseRise = sckRiseCount;
        baseValid = doValidCount;
        applyStimulus(8'hA5, 1'b0);
        waitDone(baseValid + 1);
        checkOutput("a5_do", 32'(doWord), 32'(expectedRx(8'hA5)));
        checkOutput("a5_do_valid_count", 32'(doValidCount - baseValid), 32'd1);
        checkOutput("a5_sck_rises", 32'(sckRiseCount - baseRise), 32'd8);
        checkOutput("a5_ssel_idle", 32'(spiSsel), 32'd1);
        checkOutput("a5_sck_idle", 32'(spiSck), 32'd0);
        checkOutput("a5_di_req_idle", 32'(diReq), 32'd1);

        // Four words streamed with wren held high.
        $display("[TB] streaming four words");
        misoInvert = 1'b1;
        baseRise = sckRiseCount;
        baseValid = doValidCount;
        baseAck = wrAckCount;
        baseSselRise = sselRiseCount;
        baseSselFall = sselFallCount;
        for (int i = 0; i < 4; i++) applyStimulus(streamWords[i], 1'b1);
        wren = 1'b0;
        waitDone(baseValid + 4);
        checkOutput("stream_sck_rises", 32'(sckRiseCount - baseRise), 32'd32);
        checkOutput("stream_ssel_falls", 32'(sselFallCount - baseSselFall), 32'd1);
        checkOutput("stream_ssel_rises", 32'(sselRiseCount - baseSselRise), 32'd1);
        checkOutput("stream_wr_acks", 32'(wrAckCount - baseAck), 32'd4);
        checkOutput("stream_do_valids", 32'(doValidCount - baseValid), 32'd4);
        checkOutput("stream_last_do", 32'(doWord), 32'(expectedRx(8'h00)));

        // Reset in the middle of a word.
        $display("[TB] reset mid-transfer");
        baseRise = sckRiseCount;
        baseValid = doValidCount;
        applyStimulus(8'h5A, 1'b0);
        n = 0;
        while (sckRiseCount < baseRise + 3 && n < 500) begin
            @(negedge pclk);
            n++;
        end
        checkOutput("abort_reached_3_rises", 32'(sckRiseCount - baseRise), 32'd3);
        rst = 1'b1;
        @(negedge pclk);
        checkOutput("abort_ssel", 32'(spiSsel), 32'd1);
        checkOutput("abort_sck", 32'(spiSck), 32'd0);
        checkOutput("abort_mosi", 32'(spiMosi), 32'd0);
        checkOutput("abort_di_req", 32'(diReq), 32'd0);
        checkOutput("abort_do", 32'(doWord), 32'd0);
        rst = 1'b0;
        txQueue.delete();
        rxQueue.delete();
        @(negedge pclk);
        checkOutput("abort_di_req_rise", 32'(diReq), 32'd1);
        repeat (20) @(negedge pclk);
        checkOutput("abort_no_do_valid", 32'(doValidCount - baseValid), 32'd0);
        checkOutput("abort_no_more_sck", 32'(sckRiseCount - baseRise), 32'd3);

        // Write strobe while no request is outstanding must be ignored.
        $display("[TB] ignored write");
        baseRise = sckRiseCount;
        baseValid = doValidCount;
        baseAck = wrAckCount;
        applyStimulus(8'h12, 1'b0);
        diIn = 8'h77;
        wren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            checkOutput("ignored_wr_ack", 32'(wrAck), 32'd0);
        end
        wren = 1'b0;
        diIn = 8'h00;
        waitDone(baseValid + 1);
        checkOutput("ignored_ack_count", 32'(wrAckCount - baseAck), 32'd1);
        checkOutput("ignored_sck_rises", 32'(sckRiseCount - baseRise), 32'd8);
        checkOutput("ignored_do", 32'(doWord), 32'(expectedRx(8'h12)));

        // Idle tail: no stray activity, scoreboards drained.
        baseRise = sckRiseCount;
        repeat (30) @(negedge pclk);
        checkOutput("tail_no_sck", 32'(sckRiseCount - baseRise), 32'd0);
        checkOutput("extra_events", 32'(extraEvents), 32'd0);
        checkOutput("tx_queue_empty", 32'(txQueue.size()), 32'd0);
        checkOutput("rx_queue_empty", 32'(rxQueue.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
